// File: rtl/pe_types.sv
// Shared PE array configuration and the row/beat types used by the result drain.
package pe_types;

    typedef struct packed {
        int unsigned NUM_CHAINS;
        int unsigned NUM_RESULTS_PER_CYCLE;
        int unsigned RESULT_WIDTH;
        int unsigned TOTAL_LATENCY;
    } pe_cfg_t;

    localparam pe_cfg_t cfg = '{
        NUM_CHAINS:            4,
        NUM_RESULTS_PER_CYCLE: 2,
        RESULT_WIDTH:          16,
        TOTAL_LATENCY:         8
    };

    localparam int DRAIN_BEAT_W = int'(cfg.NUM_RESULTS_PER_CYCLE * cfg.RESULT_WIDTH);
    localparam int DRAIN_ROW_W  = int'(cfg.NUM_CHAINS) * DRAIN_BEAT_W;

    // Rows still travelling through the array when the throttle rises must still fit.
    localparam int DRAIN_ALMOST_FULL_MARGIN = int'(cfg.TOTAL_LATENCY);

    typedef logic [DRAIN_BEAT_W-1:0] pe_drain_beat_t;
    typedef logic [DRAIN_ROW_W-1:0]  pe_drain_row_t;

    typedef enum logic {
        DRAIN_IDLE,
        DRAIN_SEND
    } pe_drain_state_e;

endpackage

// File: rtl/pe_drain_fifo.sv
// Single-clock row FIFO with show-ahead head output, occupancy counter and
// a registered almost-full flag.
module pe_drain_fifo #(
    parameter int WIDTH     = 128,
    parameter int DEPTH     = 32,
    parameter int AF_MARGIN = 8
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o,
    output logic             almost_full_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);
    localparam logic [AW:0] AF_LEVEL   = (AW+1)'(DEPTH - AF_MARGIN);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wrPtr_q;
    logic [AW-1:0]    rdPtr_q;
    logic [AW:0]      count_q;
    logic [AW:0]      count_d;
    logic             almostFull_q;
    logic             pushOk;
    logic             popOk;

    assign full_o        = (count_q == FULL_LEVEL);
    assign empty_o       = (count_q == '0);
    assign pushOk        = push_i && !full_o;
    assign popOk         = pop_i && !empty_o;
    assign rdata_o       = mem_q[rdPtr_q];
    assign almost_full_o = almostFull_q;

    // Next occupancy: a push and pop in the same cycle cancel out.
    always_comb begin
        count_d = count_q;
        if (pushOk && !popOk) begin
            count_d = count_q + 1'b1;
        end else if (popOk && !pushOk) begin
            count_d = count_q - 1'b1;
        end
    end

    // Storage array; contents need no reset because the pointers gate visibility.
    always_ff @(posedge clock) begin
        if (pushOk) begin
            mem_q[wrPtr_q] <= wdata_i;
        end
    end

    // Pointers wrap naturally since the depth is a power of two.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            wrPtr_q      <= '0;
            rdPtr_q      <= '0;
            count_q      <= '0;
            almostFull_q <= 1'b0;
        end else begin
            if (pushOk) begin
                wrPtr_q <= wrPtr_q + 1'b1;
            end
            if (popOk) begin
                rdPtr_q <= rdPtr_q + 1'b1;
            end
            count_q      <= count_d;
            almostFull_q <= (count_d >= AF_LEVEL);
        end
    end

endmodule

// File: rtl/pe_result_drain.sv
// Captures PE array result rows into a FIFO and serialises them one chain per beat.
// Optional row statistics counters are enabled with PE_RESULT_DRAIN_STATS_EN.
module pe_result_drain
    import pe_types::*;
#(
    parameter int NUM_CHAINS            = int'(cfg.NUM_CHAINS),
    parameter int NUM_RESULTS_PER_CYCLE = int'(cfg.NUM_RESULTS_PER_CYCLE),
    parameter int RESULT_WIDTH          = int'(cfg.RESULT_WIDTH),
    parameter int FIFO_DEPTH            = 32,
    parameter int ALMOST_FULL_MARGIN    = DRAIN_ALMOST_FULL_MARGIN,
    localparam int BEAT_W  = NUM_RESULTS_PER_CYCLE * RESULT_WIDTH,
    localparam int ROW_W   = NUM_CHAINS * BEAT_W,
    localparam int CHAIN_W = (NUM_CHAINS > 1) ? $clog2(NUM_CHAINS) : 1
) (
    input  logic               clock,
    input  logic               resetn,
    input  logic               i_valid,
    input  logic               i_result_valid,
    input  logic [ROW_W-1:0]   i_result,
    output logic               o_almost_full,
    output logic               o_valid,
    input  logic               i_ready,
    output logic [BEAT_W-1:0]  o_data,
    output logic [CHAIN_W-1:0] o_chain_id,
    output logic               o_last,
    output logic               o_overflow
`ifdef PE_RESULT_DRAIN_STATS_EN
    ,
    output logic [31:0]        o_rows_accepted,
    output logic [31:0]        o_rows_dropped
`endif
);

    logic                pushReq;
    logic                dropRow;
    logic                popRow;
    logic                fifoFull;
    logic                fifoEmpty;
    logic [ROW_W-1:0]    fifoHead;
    logic [ROW_W-1:0]    row_q;
    logic [CHAIN_W-1:0]  chain_q;
    logic [CHAIN_W-1:0]  chainNext;
    logic [BEAT_W-1:0]   data_q;
    logic                valid_q;
    logic                last_q;
    logic                overflow_q;
    pe_drain_state_e     state_q;

    assign pushReq   = i_valid && i_result_valid;
    assign dropRow   = pushReq && fifoFull;
    assign chainNext = chain_q + 1'b1;

    assign o_valid    = valid_q;
    assign o_data     = data_q;
    assign o_chain_id = chain_q;
    assign o_last     = last_q;
    assign o_overflow = overflow_q;

    // Take a new row when idle, or straight after the final beat so rows run back-to-back.
    always_comb begin
        popRow = 1'b0;
        if (!fifoEmpty) begin
            popRow = (state_q == DRAIN_IDLE) || (i_ready && last_q);
        end
    end

    pe_drain_fifo #(
        .WIDTH     (ROW_W),
        .DEPTH     (FIFO_DEPTH),
        .AF_MARGIN (ALMOST_FULL_MARGIN)
    ) u_fifo (
        .clock         (clock),
        .resetn        (resetn),
        .push_i        (pushReq),
        .wdata_i       (i_result),
        .pop_i         (popRow),
        .rdata_o       (fifoHead),
        .full_o        (fifoFull),
        .empty_o       (fifoEmpty),
        .almost_full_o (o_almost_full)
    );

    // Serialiser FSM with registered beat outputs that hold steady while stalled.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q <= DRAIN_IDLE;
            row_q   <= '0;
            chain_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else if (popRow) begin
            state_q <= DRAIN_SEND;
            row_q   <= fifoHead;
            chain_q <= '0;
            data_q  <= fifoHead[BEAT_W-1:0];
            valid_q <= 1'b1;
            last_q  <= (NUM_CHAINS == 1);
        end else if (state_q == DRAIN_SEND && i_ready) begin
            if (last_q) begin
                state_q <= DRAIN_IDLE;
                valid_q <= 1'b0;
                last_q  <= 1'b0;
            end else begin
                chain_q <= chainNext;
                data_q  <= row_q[int'(chainNext)*BEAT_W +: BEAT_W];
                last_q  <= (int'(chainNext) == NUM_CHAINS - 1);
            end
        end
    end

    // Sticky loss flag: once a row is dropped it stays visible until reset.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            overflow_q <= 1'b0;
        end else if (dropRow) begin
            overflow_q <= 1'b1;
        end
    end

`ifdef PE_RESULT_DRAIN_STATS_EN
    logic [31:0] rowsAccepted_q;
    logic [31:0] rowsDropped_q;

    assign o_rows_accepted = rowsAccepted_q;
    assign o_rows_dropped  = rowsDropped_q;

    // Free-running row counters that wrap at 2^32.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            rowsAccepted_q <= '0;
            rowsDropped_q  <= '0;
        end else begin
            if (pushReq && !fifoFull) begin
                rowsAccepted_q <= rowsAccepted_q + 1'b1;
            end
            if (dropRow) begin
                rowsDropped_q <= rowsDropped_q + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pe_result_drain.sv
// Self-checking bench for pe_result_drain: random and directed row streams
// compared against a row-queue reference model.
module tb_pe_result_drain;

    localparam int NC       = 4;
    localparam int BW       = 32;
    localparam int DEPTH    = 32;
    localparam int AF_LEVEL = 24;

    logic         clock = 1'b0;
    logic         resetn = 1'b0;
    logic         i_valid = 1'b0;
    logic         i_result_valid = 1'b0;
    logic [127:0] i_result = '0;
    logic         i_ready = 1'b0;
    logic         o_almost_full;
    logic         o_valid;
    logic [31:0]  o_data;
    logic [1:0]   o_chain_id;
    logic         o_last;
    logic         o_overflow;
`ifdef PE_RESULT_DRAIN_STATS_EN
    logic [31:0]  o_rows_accepted;
    logic [31:0]  o_rows_dropped;
`endif

    int checks = 0;
    int errors = 0;

    logic [127:0] rowQ[$];
    logic [127:0] curRow;
    int           curIdx;
    bit           busy;
    bit           mOverflow;
    int unsigned  mAccepted;
    int unsigned  mDropped;

    pe_result_drain u_dut (
        .clock          (clock),
        .resetn         (resetn),
        .i_valid        (i_valid),
        .i_result_valid (i_result_valid),
        .i_result       (i_result),
        .o_almost_full  (o_almost_full),
        .o_valid        (o_valid),
        .i_ready        (i_ready),
        .o_data         (o_data),
        .o_chain_id     (o_chain_id),
        .o_last         (o_last),
        .o_overflow     (o_overflow)
`ifdef PE_RESULT_DRAIN_STATS_EN
        ,
        .o_rows_accepted(o_rows_accepted),
        .o_rows_dropped (o_rows_dropped)
`endif
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Compares every visible output with what the row queue model says is presented.
    task automatic compareState(input string phase);
        checkOutput({phase, ".valid"}, o_valid, busy);
        if (busy) begin
            checkOutput({phase, ".data"}, o_data, curRow[curIdx*BW +: BW]);
            checkOutput({phase, ".chain"}, o_chain_id, curIdx);
            checkOutput({phase, ".last"}, o_last, (curIdx == NC - 1));
        end
        checkOutput({phase, ".occ"}, u_dut.u_fifo.count_q, rowQ.size());
        checkOutput({phase, ".af"}, o_almost_full, (rowQ.size() >= AF_LEVEL));
        checkOutput({phase, ".ovf"}, o_overflow, mOverflow);
`ifdef PE_RESULT_DRAIN_STATS_EN
        checkOutput({phase, ".acc"}, o_rows_accepted, mAccepted);
        checkOutput({phase, ".drop"}, o_rows_dropped, mDropped);
`endif
    endtask

    // One clock cycle: drive inputs, advance the model across the edge, then check.
    task automatic applyStimulus(input string phase, input bit v, input bit rv,
                                 input logic [127:0] row, input bit rdy);
        bit beat;
        bit popNow;
        bit pushReq;
        bit wasFull;
        i_valid        = v;
        i_result_valid = rv;
        i_result       = row;
        i_ready        = rdy;
        beat    = busy && rdy;
        popNow  = (rowQ.size() != 0) && (!busy || (beat && curIdx == NC - 1));
        pushReq = v && rv;
        wasFull = (rowQ.size() == DEPTH);
        @(posedge clock);
        if (beat) begin
            curIdx++;
            if (curIdx == NC) busy = 1'b0;
        end
        if (popNow) begin
            curRow = rowQ.pop_front();
            curIdx = 0;
            busy   = 1'b1;
        end
        if (pushReq) begin
            if (wasFull) begin
                mOverflow = 1'b1;
                mDropped++;
            end else begin
                rowQ.push_back(row);
                mAccepted++;
            end
        end
        #1;
        compareState(phase);
    endtask

    task automatic doReset(input int cycles);
        resetn         = 1'b0;
        i_valid        = 1'b0;
        i_result_valid = 1'b0;
        repeat (cycles) @(posedge clock);
        rowQ.delete();
        busy      = 1'b0;
        curIdx    = 0;
        mOverflow = 1'b0;
        mAccepted = 0;
        mDropped  = 0;
        #1;
        compareState("reset");
        checkOutput("reset.data0", o_data, 0);
        checkOutput("reset.chain0", o_chain_id, 0);
        checkOutput("reset.last0", o_last, 0);
        resetn = 1'b1;
    endtask

    task automatic drainAll(input string phase);
        for (int i = 0; i < 400 && (busy || rowQ.size() != 0); i++) begin
            applyStimulus(phase, 1'b0, 1'b0, '0, 1'b1);
        end
        checkOutput({phase, ".drained"}, o_valid, 0);
    endtask

    function automatic logic [127:0] randRow();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        logic [127:0] seqRow;
        busy = 1'b0; curIdx = 0; mOverflow = 1'b0; mAccepted = 0; mDropped = 0;
        doReset(3);

        // Single known row: first beat visible one edge after the push edge.
        for (int k = 0; k < 8; k++) seqRow[k*16 +: 16] = 16'(k + 1);
        applyStimulus("single", 1'b1, 1'b1, seqRow, 1'b1);
        checkOutput("single.notYet", o_valid, 0);
        applyStimulus("single", 1'b0, 1'b0, '0, 1'b1);
        checkOutput("single.beat0", o_data, 32'h0002_0001);
        applyStimulus("single", 1'b0, 1'b0, '0, 1'b1);
        checkOutput("single.beat1", o_data, 32'h0004_0003);
        drainAll("single");

        // Valid without result-valid must not push; then three rows back-to-back.
        applyStimulus("noResult", 1'b1, 1'b0, randRow(), 1'b1);
        for (int r = 0; r < 3; r++) applyStimulus("b2b", 1'b1, 1'b1, randRow(), 1'b1);
        drainAll("b2b");

        // Stall and fill to the almost-full level.
        for (int r = 0; r < 25; r++) applyStimulus("stallAf", 1'b1, 1'b1, randRow(), 1'b0);
        repeat (3) applyStimulus("stallHold", 1'b0, 1'b0, '0, 1'b0);
        checkOutput("stallAf.high", o_almost_full, 1);
        drainAll("stallAf");

        // Overrun the FIFO while stalled; loss flag stays set through the drain.
        for (int r = 0; r < 35; r++) applyStimulus("ovf", 1'b1, 1'b1, randRow(), 1'b0);
        checkOutput("ovf.flag", o_overflow, 1);
        checkOutput("ovf.occFull", u_dut.u_fifo.count_q, DEPTH);
        drainAll("ovfDrain");
        checkOutput("ovf.sticky", o_overflow, 1);
        doReset(1);

        // Simultaneous push and pop at occupancy 31.
        for (int r = 0; r < 32; r++) applyStimulus("occ31", 1'b1, 1'b1, randRow(), 1'b0);
        for (int b = 0; b < 3; b++) applyStimulus("occ31", 1'b0, 1'b0, '0, 1'b1);
        applyStimulus("occ31", 1'b1, 1'b1, randRow(), 1'b1);
        checkOutput("occ31.hold", u_dut.u_fifo.count_q, 31);
        drainAll("occ31");

        // Random push stream with random backpressure.
        for (int c = 0; c < 1500; c++) begin
            applyStimulus("random", ($urandom_range(0, 99) < 14), ($urandom_range(0, 99) < 85),
                          randRow(), ($urandom_range(0, 1) == 1));
        end
        drainAll("random");

        // Reset in the middle of a row discards it.
        applyStimulus("midRst", 1'b1, 1'b1, randRow(), 1'b1);
        applyStimulus("midRst", 1'b1, 1'b1, randRow(), 1'b1);
        applyStimulus("midRst", 1'b0, 1'b0, '0, 1'b1);
        applyStimulus("midRst", 1'b0, 1'b0, '0, 1'b1);
        doReset(1);
        checkOutput("midRst.valid", o_valid, 0);
        checkOutput("midRst.occ", u_dut.u_fifo.count_q, 0);
        applyStimulus("postRst", 1'b1, 1'b1, randRow(), 1'b1);
        applyStimulus("postRst", 1'b0, 1'b0, '0, 1'b1);
        checkOutput("postRst.chain", o_chain_id, 0);
        drainAll("postRst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
